// File: rtl/alu_acc_stage.sv
// alu_acc_stage
//   Downstream stage of the 8-bit ALU. Captures the ALU result into an
//   accumulator, derives {Z,C,N,V} status flags from the operands and
//   opcode, and queues {flags,result} in a small show-ahead FIFO for a
//   valid/ready write-back consumer that may stall.
//
// Optional feature macro: ACC_SAT_EN
//   defined   : add with carry saturates to all-ones, subtract with borrow
//               saturates to zero (Z/N follow the saturated value, C/V the raw)
//   undefined : result is alu_dout unchanged (wrap-around)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-low
//   alus      in   [3:0] ALU opcode (0000-1010 legal)
//   x, bus    in   [WIDTH-1:0] ALU operands
//   alu_dout  in   [WIDTH-1:0] ALU result (trusted)
//   ld        in   capture request
//   in_ready  out  queue has room this cycle
//   acc       out  [WIDTH-1:0] accumulator
//   flags     out  [3:0] {Z,C,N,V} of last accepted result
//   wb_valid  out  queue head valid
//   wb_ready  in   consumer accepts head
//   wb_data   out  [WIDTH-1:0] queue head result
//   wb_flags  out  [3:0] queue head flags
//   count     out  [$clog2(DEPTH):0] queue occupancy
//   drop      out  one-cycle pulse: legal ld rejected because the queue was full
//   op_err    out  sticky: ld seen with an illegal opcode
module alu_acc_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               alus,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         bus,
  input  logic [WIDTH-1:0]         alu_dout,
  input  logic                     ld,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         acc,
  output logic [3:0]               flags,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [WIDTH-1:0]         wb_data,
  output logic [3:0]               wb_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop,
  output logic                     op_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Raw carry/borrow and signed overflow, returned as {C,V}.
  function automatic logic [1:0] calc_cv(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic               [WIDTH:0] sum_u;
    logic               [WIDTH:0] dif_u;
    logic signed        [WIDTH:0] sum_s;
    logic signed        [WIDTH:0] dif_s;
    logic c;
    logic v;
    sum_u = {1'b0, a} + {1'b0, b};
    dif_u = {1'b0, a} - {1'b0, b};
    sum_s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    dif_s = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0001: begin c = sum_u[WIDTH]; v = sum_s[WIDTH] ^ sum_s[WIDTH-1]; end
      4'b0010: begin c = dif_u[WIDTH]; v = dif_s[WIDTH] ^ dif_s[WIDTH-1]; end
      4'b0011: begin c = &a;  v = (a == {1'b0, {(WIDTH-1){1'b1}}}); end
      4'b0100: begin c = ~|a; v = (a == {1'b1, {(WIDTH-1){1'b0}}}); end
      4'b1001: c = a[WIDTH-1];
      default: ;
    endcase
    return {c, v};
  endfunction

  // Saturating result: clamp add-with-carry high and subtract-with-borrow low.
  function automatic logic [WIDTH-1:0] sat_res(input logic [3:0] op,
                                               input logic [WIDTH-1:0] d,
                                               input logic c);
    logic [WIDTH-1:0] r;
    r = d;
    if (op == 4'b0001 && c) r = {WIDTH{1'b1}};
    if (op == 4'b0010 && c) r = {WIDTH{1'b0}};
    return r;
  endfunction

  logic [1:0]       w_cv;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic             w_rej;

  logic [WIDTH-1:0]   r_acc;
  logic [3:0]         r_flags;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic               r_drop;
  logic               r_op_err;
  logic [WIDTH+3:0]   r_mem [DEPTH];

  // Stage input: flag derivation and accept decision (combinational)
  assign w_cv = calc_cv(alus, x, bus);
`ifdef ACC_SAT_EN
  assign w_res = sat_res(alus, alu_dout, w_cv[1]);
`else
  assign w_res = alu_dout;
`endif
  assign w_flags = {(w_res == '0), w_cv[1], w_res[WIDTH-1], w_cv[0]};

  assign w_legal  = (alus <= 4'b1010);
  assign in_ready = (r_count < DEPTH_C);
  assign w_push   = ld & w_legal & in_ready;
  assign w_rej    = ld & w_legal & ~in_ready;
  assign w_pop    = wb_valid & wb_ready;

  // Stage output: accumulator, status and queue control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc    <= '0;
      r_flags  <= '0;
      r_count  <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_drop   <= 1'b0;
      r_op_err <= 1'b0;
    end else begin
      r_drop <= w_rej;
      if (ld && !w_legal) r_op_err <= 1'b1;
      if (w_push) begin
        r_acc   <= w_res;
        r_flags <= w_flags;
        r_wr    <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue storage holds data only; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_flags, w_res};
  end

  assign acc      = r_acc;
  assign flags    = r_flags;
  assign count    = r_count;
  assign drop     = r_drop;
  assign op_err   = r_op_err;
  assign wb_valid = (r_count != '0);
  assign wb_data  = r_mem[r_rd][WIDTH-1:0];
  assign wb_flags = r_mem[r_rd][WIDTH+3:WIDTH];

endmodule

// File: tb/tb_alu_acc_stage.sv
// Self-checking bench for alu_acc_stage: directed steps, scoreboard queue
// for the write-back stream, immediate assertions at every comparison.
module tb_alu_acc_stage;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] alus;
  logic [7:0] x, bus, alu_dout;
  logic       ld;
  logic       in_ready;
  logic [7:0] acc;
  logic [3:0] flags;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [3:0] wb_flags;
  logic [2:0] count;
  logic       drop;
  logic       op_err;

  alu_acc_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alus(alus), .x(x), .bus(bus), .alu_dout(alu_dout),
    .ld(ld), .in_ready(in_ready), .acc(acc), .flags(flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_flags(wb_flags), .count(count), .drop(drop), .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] q[$];
  logic [7:0]  exp_acc;
  logic [3:0]  exp_flags;
  logic        exp_drop;
  logic        exp_err;
  logic [7:0]  acc_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: returns {Z,C,N,V,res} using integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] xx,
                                        input logic [7:0] bb, input logic [7:0] dd);
    int ux, ub, sx, sb;
    logic c, v, z, n;
    logic [7:0] res;
    ux = int'(xx); ub = int'(bb);
    sx = int'($signed(xx)); sb = int'($signed(bb));
    c = 1'b0; v = 1'b0; res = dd;
    case (op)
      4'd1: begin
        c = (ux + ub) > 255;
        v = (sx + sb > 127) || (sx + sb < -128);
`ifdef ACC_SAT_EN
        if (c) res = 8'hFF;
`endif
      end
      4'd2: begin
        c = ux < ub;
        v = (sx - sb > 127) || (sx - sb < -128);
`ifdef ACC_SAT_EN
        if (c) res = 8'h00;
`endif
      end
      4'd3: begin c = (ux == 255); v = (sx + 1 > 127); end
      4'd4: begin c = (ux == 0);   v = (sx - 1 < -128); end
      4'd9: c = xx[7];
      default: ;
    endcase
    z = (res == 8'h00);
    n = res[7];
    return {z, c, n, v, res};
  endfunction

  // One clock: scoreboard bookkeeping before the edge, state checks after it.
  task automatic tick();
    logic [11:0] m;
    logic legal, take;
    @(negedge clk);
    legal = (alus <= 4'd10);
    m = model(alus, x, bus, alu_dout);
    if (!rst) begin
      q.delete();
      exp_acc = 8'h00; exp_flags = 4'h0; exp_drop = 1'b0; exp_err = 1'b0;
    end else begin
      take = ld && legal && (q.size() < DEPTH);
      exp_drop = ld && legal && (q.size() >= DEPTH);
      if (ld && !legal) exp_err = 1'b1;
      if (wb_valid && wb_ready) begin
        if (q.size() == 0) chk("pop_with_empty_scoreboard", q.size(), 1);
        else begin
          chk("wb_head", {wb_flags, wb_data}, q[0]);
          void'(q.pop_front());
        end
      end
      if (take) begin
        q.push_back(m);
        exp_acc = m[7:0];
        exp_flags = m[11:8];
      end
    end
    @(posedge clk);
    #1;
    chk("count", count, q.size());
    chk("wb_valid", wb_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("acc", acc, exp_acc);
    chk("flags", flags, exp_flags);
    chk("drop", drop, exp_drop);
    chk("op_err", op_err, exp_err);
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] xx,
                       input logic [7:0] bb, input logic [7:0] dd);
    alus = op; x = xx; bus = bb; alu_dout = dd; ld = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() > 0; i++) tick();
    chk("drain_done_count", count, 0);
    chk("drain_done_valid", wb_valid, 0);
  endtask

  initial begin
    rst = 1'b0; alus = 4'h0; x = 8'h00; bus = 8'h00; alu_dout = 8'h00;
    ld = 1'b0; wb_ready = 1'b0;
    exp_acc = 8'h00; exp_flags = 4'h0; exp_drop = 1'b0; exp_err = 1'b0;

    // Reset for two cycles
    tick(); tick();
    rst = 1'b1;
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", flags, 4'h0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_drop", drop, 0);

    // Add with carry: latency 1 to acc and wb head
    wb_ready = 1'b0;
    drive(4'b0001, 8'hF0, 8'h20, 8'h10);
    tick();
    ld = 1'b0;
`ifdef ACC_SAT_EN
    chk("add_carry_acc", acc, 8'hFF);
    chk("add_carry_flags", flags, 4'b0110);
    chk("add_carry_wb_data", wb_data, 8'hFF);
`else
    chk("add_carry_acc", acc, 8'h10);
    chk("add_carry_flags", flags, 4'b0100);
    chk("add_carry_wb_data", wb_data, 8'h10);
`endif
    chk("add_carry_wb_valid", wb_valid, 1);

    wb_ready = 1'b1;
    // Subtract equal operands: zero, no borrow
    drive(4'b0010, 8'h05, 8'h05, 8'h00);
    tick();
    chk("sub_eq_flags", flags, 4'b1000);
    // Add 7F+FF: carry, no overflow
    drive(4'b0001, 8'h7F, 8'hFF, 8'h7E);
    tick();
    chk("add_7f_ff_C", flags[2], 1);
    chk("add_7f_ff_V", flags[0], 0);
    // Add 7F+01: signed overflow, negative
    drive(4'b0001, 8'h7F, 8'h01, 8'h80);
    tick();
    chk("add_ovf_flags", flags, 4'b0011);
    chk("add_ovf_acc", acc, 8'h80);
    // Opcode 0000 yields zero result
    drive(4'b0000, 8'h33, 8'h44, 8'h00);
    tick();
    chk("op0_flags", flags, 4'b1000);
    // Increment at FF, decrement at 80, shift-out of bit 7
    drive(4'b0011, 8'hFF, 8'h00, 8'h00);
    tick();
    chk("inc_ff_flags", flags, 4'b1100);
    drive(4'b0100, 8'h80, 8'h00, 8'h7F);
    tick();
    chk("dec_80_flags", flags, 4'b0001);
    drive(4'b1001, 8'h81, 8'h00, 8'h02);
    tick();
    chk("shl_flags", flags, 4'b0100);
    ld = 1'b0;
    drain();

    // Fill the queue with the consumer stalled; fifth ld is dropped
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 8'(i * 16 + 1), 8'h01, 8'(i * 16 + 2));
      tick();
      if (i == 3) begin
        acc_hold = acc;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
      end
    end
    chk("full_drop", drop, 1);
    chk("full_acc_hold", acc, acc_hold);
    chk("full_acc_4th", acc, 8'h32);
    ld = 1'b0;
    tick();
    chk("drop_pulse_end", drop, 0);

    // Drain in push order
    wb_ready = 1'b1;
    drain();

    // Two queued, then push and pop together
    wb_ready = 1'b0;
    drive(4'b0010, 8'h10, 8'h01, 8'h0F); tick();
    drive(4'b0010, 8'h20, 8'h01, 8'h1F); tick();
    chk("two_count", count, 2);
    drive(4'b0010, 8'h30, 8'h01, 8'h2F);
    wb_ready = 1'b1;
    tick();
    chk("push_pop_count", count, 2);
    wb_ready = 1'b0;
    acc_hold = acc;
    drive(4'b1100, 8'h55, 8'h66, 8'h77);
    tick();
    ld = 1'b0;
    chk("illegal_op_err", op_err, 1);
    chk("illegal_acc", acc, acc_hold);
    chk("illegal_count", count, 2);
    chk("illegal_no_drop", drop, 0);

    // Reset during an active transfer with three entries queued
    drive(4'b0001, 8'h01, 8'h01, 8'h02); tick();
    ld = 1'b0;
    chk("pre_rst_count", count, 3);
    wb_ready = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", wb_valid, 0);
    chk("mid_rst_acc", acc, 8'h00);
    chk("mid_rst_op_err", op_err, 0);

    // Post-reset sanity: queue works again with wrapped pointers reset
    drive(4'b0001, 8'h01, 8'h02, 8'h03); tick();
    ld = 1'b0;
    chk("post_rst_wb_data", wb_data, 8'h03);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
